led_flash_sched: RTL and testbench

Scheduler that shares the single user LED between two flash requesters and a background heartbeat on the MachXO2 macro-keypad. Each requester submits a flash command: a number of flashes plus on-time and off-time in 10 ms ticks. The block arbitrates between them, runs the granted pattern, and otherwise blinks a heartbeat. It runs from the internal 12.09 MHz oscillator clock and drives the LED pin directly.

---
 rtl/led_flash_sched.sv | 137 +++++++++++++
 tb/tb_led_flash_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/led_flash_sched.sv
// led_flash_sched: shares one LED between two flash requesters and a heartbeat.
// Define LED_SCHED_RR_EN for round-robin arbitration of simultaneous requests.
module led_flash_sched #(
    parameter int TICK_DIV = 120900,
    parameter int HB_TICKS = 82
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_count,
    input  logic [15:0] req_on,
    input  logic [15:0] req_off,
    output logic        busy,
    output logic        grant_id,
    output logic        done,
    output logic        led
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HB_TICKS + 1);

    typedef enum logic [1:0] {HB, ON, OFF} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    phase_q, phase_d, on_q, on_d, off_q, off_d;
    logic [HW-1:0] hb_q, hb_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    rdy_q, rdy_d;
    logic          led_q, led_d, busy_q, busy_d, done_q, done_d, gid_q, gid_d;
    logic          tick, g;
    logic [3:0]    c_sel;
    logic [7:0]    on_sel, off_sel;

    assign tick = presc_q == PW'(TICK_DIV - 1);
`ifdef LED_SCHED_RR_EN
    assign g = &req_valid ? ~gid_q : ~req_valid[0];
`else
    assign g = ~req_valid[0];
`endif
    assign c_sel   = g ? req_count[7:4]  : req_count[3:0];
    assign on_sel  = g ? req_on[15:8]    : req_on[7:0];
    assign off_sel = g ? req_off[15:8]   : req_off[7:0];

    always_comb begin
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + PW'(1);
        phase_d = phase_q;
        on_d    = on_q;
        off_d   = off_q;
        hb_d    = hb_q;
        cnt_d   = cnt_q;
        rdy_d   = 2'b00;
        led_d   = led_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        gid_d   = gid_q;
        case (state_q)
            HB: begin
                if (|req_valid) begin
                    state_d = ON;
                    presc_d = '0;
                    phase_d = '0;
                    cnt_d   = c_sel == 4'd0 ? 4'd1 : c_sel;
                    on_d    = on_sel == 8'd0 ? 8'd1 : on_sel;
                    off_d   = off_sel == 8'd0 ? 8'd1 : off_sel;
                    rdy_d   = g ? 2'b10 : 2'b01;
                    gid_d   = g;
                    busy_d  = 1'b1;
                    led_d   = 1'b1;
                end else if (tick) begin
                    led_d = hb_q == HW'(HB_TICKS - 1) ? ~led_q : led_q;
                    hb_d  = hb_q == HW'(HB_TICKS - 1) ? '0 : hb_q + HW'(1);
                end
            end
            ON: begin
                if (tick) begin
                    phase_d = phase_q == on_q - 8'd1 ? 8'd0 : phase_q + 8'd1;
                    if (phase_q == on_q - 8'd1) begin
                        state_d = OFF;
                        led_d   = 1'b0;
                    end
                end
            end
            OFF: begin
                if (tick) begin
                    phase_d = phase_q == off_q - 8'd1 ? 8'd0 : phase_q + 8'd1;
                    if (phase_q == off_q - 8'd1) begin
                        cnt_d   = cnt_q - 4'd1;
                        state_d = cnt_q == 4'd1 ? HB : ON;
                        led_d   = cnt_q != 4'd1;
                        done_d  = cnt_q == 4'd1;
                        busy_d  = cnt_q != 4'd1;
                        hb_d    = '0;
                    end
                end
            end
            default: state_d = HB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HB;
            presc_q <= '0;
            phase_q <= '0;
            on_q    <= '0;
            off_q   <= '0;
            hb_q    <= '0;
            cnt_q   <= '0;
            rdy_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            on_q    <= on_d;
            off_q   <= off_d;
            hb_q    <= hb_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gid_q   <= gid_d;
        end
    end

    assign req_ready = rdy_q;
    assign busy      = busy_q;
    assign grant_id  = gid_q;
    assign done      = done_q;
    assign led       = led_q;
endmodule

// File: tb/tb_led_flash_sched.sv
// tb_led_flash_sched: scoreboard bench; per-cycle expected {led,busy,done,req_ready,grant_id}.
module tb_led_flash_sched;
    localparam int TD = 4;
    localparam int HT = 3;

    logic        clk, rst_n;
    logic [1:0]  req_valid, req_ready;
    logic [7:0]  req_count;
    logic [15:0] req_on, req_off;
    logic        busy, grant_id, done, led;

    int total = 0;
    int bad = 0;
    logic cur_gid = 1'b0;
    logic [5:0] sb[$];

    led_flash_sched #(.TICK_DIV(TD), .HB_TICKS(HT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_count(req_count), .req_on(req_on), .req_off(req_off),
        .busy(busy), .grant_id(grant_id), .done(done), .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] mk(input logic l, input logic b, input logic d,
                                      input logic [1:0] r, input logic gi);
        return {l, b, d, r, gi};
    endfunction

    function automatic logic winner();
`ifdef LED_SCHED_RR_EN
        return (&req_valid) ? ~cur_gid : ~req_valid[0];
`else
        return ~req_valid[0];
`endif
    endfunction

    task automatic push_pat(input logic gg, input int cnt, input int on, input int off);
        int c = cnt == 0 ? 1 : cnt;
        int o = on == 0 ? 1 : on;
        int f = off == 0 ? 1 : off;
        int per = (o + f) * TD;
        for (int i = 0; i < c * per; i++)
            sb.push_back(mk((i % per) < o * TD, 1'b1, 1'b0, i == 0 ? (gg ? 2'b10 : 2'b01) : 2'b00, gg));
        sb.push_back(mk(1'b0, 1'b0, 1'b1, 2'b00, gg));
        cur_gid = gg;
    endtask

    task automatic push_tail();
        for (int i = 1; i < HT * TD; i++) sb.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, cur_gid));
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, cur_gid));
    endtask

    task automatic push_hb(input int n);
        for (int k = 1; k <= n; k++) sb.push_back(mk(((k / (HT * TD)) % 2) == 1, 1'b0, 1'b0, 2'b00, 1'b0));
    endtask

    task automatic drain(input string name, input int n);
        logic [5:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL %s: scoreboard empty at step %0d", name, i);
            end else begin
                e = sb.pop_front();
                if ({led, busy, done, req_ready, grant_id} !== e) begin
                    bad++;
                    $display("FAIL %s step %0d: got led/busy/done/rdy/gid=%b required %b",
                             name, i, {led, busy, done, req_ready, grant_id}, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_count = 8'h00;
        req_on = 16'h0000;
        req_off = 16'h0000;
        repeat (3) @(negedge clk);
        total++;
        if ({led, busy, done, req_ready, grant_id} !== 6'b0) begin
            bad++;
            $display("FAIL reset_state: got %b required 000000", {led, busy, done, req_ready, grant_id});
        end
        rst_n = 1'b1;
        push_hb(36);
        drain("heartbeat", 36);
    endtask

    task automatic test_two_flash();
        req_count = 8'hF2;
        req_on = 16'h0703;
        req_off = 16'h0501;
        req_valid = 2'b01;
        push_pat(winner(), 2, 3, 1);
        push_tail();
        drain("two_flash", 1);
        req_valid = 2'b00;
        req_count = 8'h55;
        req_on = 16'h0909;
        req_off = 16'h0909;
        drain("two_flash", 44);
    endtask

    task automatic test_zero_fields();
        req_count = 8'h00;
        req_on = 16'h0000;
        req_off = 16'h0000;
        req_valid = 2'b01;
        push_pat(winner(), 0, 0, 0);
        push_tail();
        drain("zero_fields", 1);
        req_valid = 2'b00;
        drain("zero_fields", 20);
    endtask

    task automatic test_busy_defer();
        req_count = 8'h11;
        req_on = 16'h0102;
        req_off = 16'h0101;
        req_valid = 2'b01;
        push_pat(winner(), 1, 2, 1);
        drain("busy_defer", 1);
        req_valid = 2'b00;
        drain("busy_defer", 1);
        req_valid = 2'b10;
        push_pat(winner(), 1, 1, 1);
        push_tail();
        drain("busy_defer", 11);
        drain("busy_defer", 1);
        req_valid = 2'b00;
        drain("busy_defer", 20);
    endtask

    task automatic test_back_to_back();
        req_count = 8'h11;
        req_on = 16'h0101;
        req_off = 16'h0101;
        req_valid = 2'b11;
        push_pat(winner(), 1, 1, 1);
        push_pat(winner(), 1, 1, 1);
        push_pat(winner(), 1, 1, 1);
        push_tail();
        drain("back_to_back", 19);
        req_valid = 2'b00;
        drain("back_to_back", 20);
    endtask

    task automatic test_reset_mid();
        req_count = 8'h01;
        req_on = 16'h0005;
        req_off = 16'h0001;
        req_valid = 2'b01;
        for (int i = 0; i < 4; i++) sb.push_back(mk(1'b1, 1'b1, 1'b0, i == 0 ? 2'b01 : 2'b00, 1'b0));
        drain("reset_mid", 1);
        req_valid = 2'b00;
        drain("reset_mid", 3);
        rst_n = 1'b0;
        #1;
        total++;
        if ({led, busy, done, req_ready, grant_id} !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid_async: got %b required 000000", {led, busy, done, req_ready, grant_id});
        end
        @(negedge clk);
        total++;
        if ({led, busy, done, req_ready, grant_id} !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid_hold: got %b required 000000", {led, busy, done, req_ready, grant_id});
        end
        rst_n = 1'b1;
        cur_gid = 1'b0;
        push_hb(24);
        drain("reset_mid_hb", 24);
    endtask

    initial begin
        test_reset();
        test_two_flash();
        test_zero_fields();
        test_busy_defer();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
